// File: rtl/chip8_alu_seq.sv
// CHIP-8 style ALU with a valid/ready request/response handshake and a held result register.
// Define CHIP8_ALU_BCD_EN to build the multi-cycle double-dabble BCD operation.
package chip8_alu_pkg;
  typedef enum logic [3:0] {
    ALU_f_NOP     = 4'd0,
    ALU_f_OR      = 4'd1,
    ALU_f_AND     = 4'd2,
    ALU_f_XOR     = 4'd3,
    ALU_f_ADD     = 4'd4,
    ALU_f_MINUS   = 4'd5,
    ALU_f_LSHIFT  = 4'd6,
    ALU_f_RSHIFT  = 4'd7,
    ALU_f_EQUALS  = 4'd8,
    ALU_f_GREATER = 4'd9,
    ALU_f_MSB     = 4'd10,
    ALU_f_LSB     = 4'd11,
    ALU_f_INC     = 4'd12,
    ALU_f_BCD     = 4'd13
  } ALU_f;
endpackage

module chip8_alu_seq
  import chip8_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  ALU_f             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             alu_carry,
  output logic             busy
);

`ifdef CHIP8_ALU_BCD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_e;
  localparam int BW = (WIDTH < 12) ? WIDTH : 12;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd2} state_e;
`endif

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic [WIDTH:0]   sum_w, shl_w, shr_w;

`ifdef CHIP8_ALU_BCD_EN
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] bcd_q, bcd_d, adj;
  logic [7:0]  bin_q, bin_d;

  function automatic logic [11:0] dd_adj(input logic [11:0] v);
    for (int i = 0; i < 3; i++)
      if (v[i*4 +: 4] >= 4'd5) v[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    return v;
  endfunction
`endif

  // Shifts run on a one-bit-wider word so the last bit shifted out lands
  // in the extra bit; a zero shift leaves that bit 0 by construction.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    sum_w = {1'b0, input1} + {1'b0, input2};
    shl_w = {1'b0, input1} << input2;
    shr_w = {input1, 1'b0} >> input2;
    case (sel)
      ALU_f_OR:      res = input1 | input2;
      ALU_f_AND:     res = input1 & input2;
      ALU_f_XOR:     res = input1 ^ input2;
      ALU_f_ADD:     {res_c, res} = sum_w;
      ALU_f_MINUS: begin
        res   = input1 - input2;
        res_c = (input1 >= input2);
      end
      ALU_f_LSHIFT:
        if (input2 < WIDTH_V) begin
          res   = shl_w[WIDTH-1:0];
          res_c = shl_w[WIDTH];
        end
      ALU_f_RSHIFT:
        if (input2 < WIDTH_V) begin
          res   = shr_w[WIDTH:1];
          res_c = shr_w[0];
        end
      ALU_f_EQUALS:  res[0] = (input1 != input2);
      ALU_f_GREATER: res[0] = !(input1 > input2);
      ALU_f_MSB:     res[0] = input1[WIDTH-1];
      ALU_f_LSB:     res[0] = input1[0];
      ALU_f_INC: begin
        res   = input1 + {{(WIDTH-1){1'b0}}, 1'b1};
        res_c = &input1;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;
  assign alu_carry = carry_q;
`ifdef CHIP8_ALU_BCD_EN
  assign busy = (state_q == RUN);
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
`ifdef CHIP8_ALU_BCD_EN
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    bin_d = bin_q;
    adj   = '0;
`endif
    case (state_q)
`ifdef CHIP8_ALU_BCD_EN
      RUN: begin
        // one double-dabble step: add-3 correction, then shift in the next binary bit
        adj            = dd_adj(bcd_q);
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d          = HOLD;
          out_d            = '0;
          out_d[BW-1:0]    = bcd_d[BW-1:0];
          carry_d          = 1'b0;
        end
      end
`endif
      default: begin
        if (in_valid && in_ready) begin
`ifdef CHIP8_ALU_BCD_EN
          if (sel == ALU_f_BCD) begin
            state_d = RUN;
            cnt_d   = '0;
            bcd_d   = '0;
            bin_d   = input1[7:0];
          end else begin
`else
          begin
`endif
            state_d = HOLD;
            out_d   = res;
            carry_d = res_c;
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
`ifdef CHIP8_ALU_BCD_EN
      cnt_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
`ifdef CHIP8_ALU_BCD_EN
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
`endif
    end
  end

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Scoreboard bench for chip8_alu_seq (WIDTH=16): expectations queued on drive, popped on result.
module tb_chip8_alu_seq;
  import chip8_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready;
  logic [15:0] input1, input2;
  ALU_f        sel;
  logic        in_ready, out_valid, alu_carry, busy;
  logic [15:0] out;

  chip8_alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .alu_carry(alu_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] o; logic c;} exp_t;
  typedef struct {ALU_f s; logic [15:0] a; logic [15:0] b; logic [15:0] o; logic c;} op_t;
  exp_t sb[$];
  int   tests = 0, fails = 0;

  function automatic exp_t model(input ALU_f s, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    int unsigned t;
    r.o = '0; r.c = 1'b0;
    case (s)
      ALU_f_OR:  r.o = a | b;
      ALU_f_AND: r.o = a & b;
      ALU_f_XOR: r.o = a ^ b;
      ALU_f_ADD: begin t = 32'(a) + 32'(b); r.o = t[15:0]; r.c = (t > 32'hFFFF); end
      ALU_f_MINUS: begin r.o = a - b; r.c = !(a < b); end
      ALU_f_LSHIFT:
        if (b < 16) begin
          for (int i = 0; i < 16; i++) if (i < b) begin r.c = a[15]; a = {a[14:0], 1'b0}; end
          r.o = a;
        end
      ALU_f_RSHIFT:
        if (b < 16) begin
          for (int i = 0; i < 16; i++) if (i < b) begin r.c = a[0]; a = {1'b0, a[15:1]}; end
          r.o = a;
        end
      ALU_f_EQUALS:  r.o = (a == b) ? 16'd0 : 16'd1;
      ALU_f_GREATER: r.o = (a > b) ? 16'd0 : 16'd1;
      ALU_f_MSB:     r.o = {15'd0, a[15]};
      ALU_f_LSB:     r.o = {15'd0, a[0]};
      ALU_f_INC:     begin r.o = a + 16'd1; r.c = (a == 16'hFFFF); end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] bcd_of(input int unsigned v);
    return {4'd0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // drive one request and hold it until the cycle it is accepted
  task automatic send(input ALU_f s, input logic [15:0] a, input logic [15:0] b, output bit ok);
    sel = s; input1 = a; input2 = b; in_valid = 1'b1; ok = 1'b0;
    #1;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  // negedges until out_valid (1 = next cycle after acceptance), 0 on timeout
  task automatic wait_out(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (out_valid) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel = ALU_f_NOP; input1 = '0; input2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0 || alu_carry !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b busy=%b out=%h c=%b, expected 0 0 0000 0", out_valid, busy, out, alu_carry);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_ops;
    op_t t[$];
    exp_t e;
    bit ok;
    int n;
    t.push_back('{ALU_f_NOP,     16'h1234, 16'h5678, 16'h0000, 1'b0});
    t.push_back('{ALU_f_OR,      16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0});
    t.push_back('{ALU_f_AND,     16'hF0F0, 16'hFF00, 16'hF000, 1'b0});
    t.push_back('{ALU_f_XOR,     16'hAAAA, 16'hFFFF, 16'h5555, 1'b0});
    t.push_back('{ALU_f_ADD,     16'hC000, 16'hC000, 16'h8000, 1'b1});
    t.push_back('{ALU_f_ADD,     16'h0001, 16'h0002, 16'h0003, 1'b0});
    t.push_back('{ALU_f_MINUS,   16'h0005, 16'h0005, 16'h0000, 1'b1});
    t.push_back('{ALU_f_LSHIFT,  16'h4F00, 16'd4,    16'hF000, 1'b0});
    t.push_back('{ALU_f_RSHIFT,  16'h0031, 16'd2,    16'h000C, 1'b0});
    t.push_back('{ALU_f_LSHIFT,  16'h8001, 16'd1,    16'h0002, 1'b1});
    t.push_back('{ALU_f_RSHIFT,  16'h8001, 16'd1,    16'h4000, 1'b1});
    t.push_back('{ALU_f_LSHIFT,  16'hFFFF, 16'd15,   16'h8000, 1'b1});
    t.push_back('{ALU_f_LSHIFT,  16'h1234, 16'd16,   16'h0000, 1'b0});
    t.push_back('{ALU_f_RSHIFT,  16'hFFFF, 16'd16,   16'h0000, 1'b0});
    t.push_back('{ALU_f_RSHIFT,  16'hFFFF, 16'd0,    16'hFFFF, 1'b0});
    t.push_back('{ALU_f_EQUALS,  16'h0007, 16'h0007, 16'h0000, 1'b0});
    t.push_back('{ALU_f_EQUALS,  16'h0007, 16'h0008, 16'h0001, 1'b0});
    t.push_back('{ALU_f_GREATER, 16'h0009, 16'h0008, 16'h0000, 1'b0});
    t.push_back('{ALU_f_GREATER, 16'h0008, 16'h0008, 16'h0001, 1'b0});
    t.push_back('{ALU_f_MSB,     16'h8000, 16'h0000, 16'h0001, 1'b0});
    t.push_back('{ALU_f_LSB,     16'hFFFE, 16'h0000, 16'h0000, 1'b0});
    t.push_back('{ALU_f_INC,     16'h00FF, 16'h0000, 16'h0100, 1'b0});
    t.push_back('{ALU_f'(4'd15), 16'h1234, 16'h0001, 16'h0000, 1'b0});
`ifndef CHIP8_ALU_BCD_EN
    t.push_back('{ALU_f_BCD,     16'd254,  16'h0000, 16'h0000, 1'b0});
`endif
    out_ready = 1'b1;
    foreach (t[i]) begin
      sb.push_back('{t[i].o, t[i].c});
      send(t[i].s, t[i].a, t[i].b, ok);
      wait_out(n);
      e = sb.pop_front();
      tests++;
      if (!ok || n != 1 || out !== e.o || alu_carry !== e.c) begin
        fails++;
        $display("FAIL ops[%0d] sel=%0d: out=%h c=%b lat=%0d, expected out=%h c=%b lat=1", i, t[i].s, out, alu_carry, n, e.o, e.c);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    exp_t e;
    ALU_f s;
    logic [15:0] a, b;
    bit ok;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s = ALU_f'(4'($urandom_range(0, 12)));
      a = 16'($urandom);
      b = (s == ALU_f_LSHIFT || s == ALU_f_RSHIFT) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      sb.push_back(model(s, a, b));
      send(s, a, b, ok);
      wait_out(n);
      e = sb.pop_front();
      tests++;
      if (!ok || n != 1 || out !== e.o || alu_carry !== e.c) begin
        fails++;
        $display("FAIL random[%0d] sel=%0d a=%h b=%h: out=%h c=%b, expected out=%h c=%b", i, s, a, b, out, alu_carry, e.o, e.c);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    out_ready = 1'b1;
    @(posedge clk); #1;
    sel = ALU_f_MINUS; input1 = 16'hE0A5; input2 = 16'h7003; in_valid = 1'b1;
    sb.push_back('{16'h70A2, 1'b1});
    sb.push_back('{16'hFFFF, 1'b0});
    @(posedge clk); #1;
    input1 = 16'h0001; input2 = 16'h0002;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out !== e.o || alu_carry !== e.c) begin
      fails++;
      $display("FAIL b2b_first: v=%b rdy=%b out=%h c=%b, expected 1 1 %h %b", out_valid, in_ready, out, alu_carry, e.o, e.c);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || out !== e.o || alu_carry !== e.c) begin
      fails++;
      $display("FAIL b2b_second: v=%b out=%h c=%b, expected 1 %h %b", out_valid, out, alu_carry, e.o, e.c);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle: out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_stall;
    exp_t e;
    bit ok;
    out_ready = 1'b0;
    sb.push_back('{16'h0000, 1'b1});
    send(ALU_f_INC, 16'hFFFF, 16'h0000, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 16'h0000 || alu_carry !== 1'b1) begin
        fails++;
        $display("FAIL stall[%0d]: v=%b rdy=%b out=%h c=%b, expected 1 0 0000 1", i, out_valid, in_ready, out, alu_carry);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || out !== e.o || alu_carry !== e.c) begin
      fails++;
      $display("FAIL stall_release: v=%b rdy=%b out=%h c=%b, expected 1 1 %h %b", out_valid, in_ready, out, alu_carry, e.o, e.c);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stall_idle: v=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

`ifdef CHIP8_ALU_BCD_EN
  task automatic test_bcd;
    int unsigned vals[$] = '{254, 0, 9, 99, 100, 255, 37};
    exp_t e;
    bit ok, run_ok;
    int n;
    out_ready = 1'b1;
    foreach (vals[i]) begin
      sb.push_back('{bcd_of(vals[i]), 1'b0});
      send(ALU_f_BCD, 16'(vals[i]), 16'h0000, ok);
      run_ok = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) run_ok = 1'b0;
      end
      wait_out(n);
      e = sb.pop_front();
      tests++;
      if (!ok || !run_ok || n != 1 || out !== e.o || alu_carry !== e.c) begin
        fails++;
        $display("FAIL bcd[%0d] in=%0d: out=%h c=%b run_ok=%b lat=%0d, expected out=%h c=%b", i, vals[i], out, alu_carry, run_ok, n + 8, e.o, e.c);
      end
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_abort;
    bit ok, seen;
    out_ready = 1'b1;
`ifdef CHIP8_ALU_BCD_EN
    send(ALU_f_BCD, 16'd254, 16'h0000, ok);
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (!ok || busy !== 1'b1) begin fails++; $display("FAIL abort_pre_busy: busy=%b expected 1", busy); end
`else
    out_ready = 1'b0;
    send(ALU_f_ADD, 16'h0001, 16'h0001, ok);
    @(negedge clk);
    tests++;
    if (!ok || out_valid !== 1'b1) begin fails++; $display("FAIL abort_pre_hold: out_valid=%b expected 1", out_valid); end
    @(posedge clk); #1;
`endif
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out !== 16'h0 || alu_carry !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_post: v=%b busy=%b out=%h c=%b rdy=%b, expected 0 0 0000 0 1", out_valid, busy, out, alu_carry, in_ready);
    end
    seen = 1'b0;
    repeat (15) begin @(negedge clk); if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL abort_no_result: stale result or busy seen=%b, expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_random();
    test_back_to_back();
    test_stall();
`ifdef CHIP8_ALU_BCD_EN
    test_bcd();
`endif
    test_reset_abort();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chip8_alu_seq.md
CHIP8_ALU_SEQ -- requirements
Module: chip8_alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 8..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 input1  input  WIDTH  operand A.
REQ-007 input2  input  WIDTH  operand B / shift amount.
REQ-008 sel  input  ALU_f  operation select (enums.svh ALU_f, extended with ALU_f_BCD).
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 out  output  WIDTH  registered result.
REQ-012 alu_carry  output  1  registered carry/flag accompanying out.
REQ-013 busy  output  1  multi-cycle operation in progress.

Function
REQ-014 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready; operands and sel are sampled only on transfer in.
REQ-015 FSM states IDLE, RUN, HOLD; in_ready = (state==IDLE) || (state==HOLD && out_ready); busy = (state==RUN); out_valid = (state==HOLD).
REQ-016 Single-cycle ops: accept in cycle N -> out/alu_carry/out_valid valid in cycle N+1 (state HOLD).
REQ-017 HOLD with out_ready=1: accepts a new request in the same cycle (back-to-back, one result per cycle); with out_ready=0: out/alu_carry held stable, in_ready=0.
REQ-018 HOLD, out_ready=1, no new request -> IDLE next cycle.
REQ-019 NOP: out=0, carry=0. OR/AND/XOR: bitwise, carry=0.
REQ-020 ADD: out = (input1+input2) mod 2^WIDTH, carry = bit WIDTH of the sum.
REQ-021 MINUS: out = (input1-input2) mod 2^WIDTH, carry = 1 iff input1 >= input2 (no borrow).
REQ-022 LSHIFT/RSHIFT: shift input1 by k = input2 (unsigned), zero fill; carry = last bit shifted out; k=0 -> carry 0; k>=WIDTH -> out 0, carry 0.
REQ-023 EQUALS: out = 0 if input1==input2 else 1; GREATER: out = 0 if input1>input2 else 1; carry=0.
REQ-024 MSB: out = {0.., input1[WIDTH-1]}; LSB: out = {0.., input1[0]}; carry=0.
REQ-025 INC: out = (input1+1) mod 2^WIDTH, carry = 1 iff input1 == all-ones.
REQ-026 BCD (multi-cycle): IDLE/HOLD -> RUN; double-dabble on input1[7:0], one shift per cycle, 8 cycles in RUN (counter 0..7), then HOLD; out[3:0]=ones, out[7:4]=tens, out[11:8]=hundreds, upper bits 0, carry=0; accept in cycle N -> out_valid in cycle N+9.
REQ-027 In RUN in_ready=0; out_ready ignored; out_valid=0.
REQ-028 Undefined sel codes behave as NOP.

Reset
REQ-029 reset_n=0 at a rising edge: state=IDLE, out=0, alu_carry=0, out_valid=0, busy=0, BCD counter/shift register cleared.
REQ-030 Reset asserted in RUN or HOLD aborts the operation; the pending result is discarded and not presented after reset.
REQ-031 in_ready=1 in the first cycle after reset_n deasserts.

Configuration
REQ-032 Macro CHIP8_ALU_BCD_EN defined: BCD op, RUN state and counter implemented per REQ-026.
REQ-033 CHIP8_ALU_BCD_EN undefined: no RUN state or BCD logic; ALU_f_BCD treated as NOP (single-cycle, out=0); busy tied 0.

Verification
REQ-034 WIDTH=16, ADD 16'hC000+16'hC000, out_ready=1 -> next cycle out=16'h8000, alu_carry=1, out_valid=1.
REQ-035 MINUS 16'hE0A5-16'h7003 then 16'h0001-16'h0002 back-to-back -> out=16'h70A2 carry=1, then out=16'hFFFF carry=0 on consecutive cycles.
REQ-036 LSHIFT 16'h4F00 by 4 -> out=16'hF000, carry=0; RSHIFT 16'h0031 by 2 -> out=16'h000C, carry=0; LSHIFT by 16 -> out=0.
REQ-037 BCD input1=8'd254 (macro defined) -> busy=1 for 8 cycles, out=16'h0254 at cycle N+9; macro undefined -> out=0 at N+1.
REQ-038 INC 16'hFFFF with out_ready=0 for 3 cycles -> out=0, carry=1 held stable, in_ready=0 throughout; release -> accepted, IDLE.
REQ-039 reset_n=0 during BCD cycle 4 -> next cycle out_valid=0, busy=0, out=0; no BCD result appears afterwards.
